// File: rtl/asynchronous_fifo_pkg.sv
// Shared constants and Gray-code helpers for the Gray-pointer FIFO.
package asynchronous_fifo_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_WIDTH = 8;

    // Helpers work on a 32-bit container; callers size-cast to their pointer width.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer carrying a Gray-coded pointer to the opposite side.
module fifo_ptr_sync
    import asynchronous_fifo_pkg::*;
#(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PTR_W-1:0] gray_in,
    output logic [PTR_W-1:0] gray_sync
);

    logic [PTR_W-1:0] sync_p0;
    logic [PTR_W-1:0] sync_p1;

    // Shift the Gray pointer through two flops; only one bit changes per step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gray_in;
            sync_p1 <= sync_p0;
        end
    end

    assign gray_sync = sync_p1;

endmodule

// File: rtl/asynchronous_fifo.sv
// Gray-pointer FIFO with synchronized pointers and registered, conservative flags.
module asynchronous_fifo
    import asynchronous_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR  = $clog2(DEPTH);
    localparam int PTR_W = ADDR + 1;

    // Full compares against the read pointer with its two MSBs flipped (Gray wrap).
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("asynchronous_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wgray;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] wq2_gray;
    logic [PTR_W-1:0] rq2_gray;
    logic             wr_accept;
    logic             rd_accept;

    // Next write pointer: advance only when the writer sees free space.
    always_comb begin
        wr_accept  = write_en && !full;
        wbin_next  = wbin + PTR_W'(wr_accept);
        wgray_next = PTR_W'(bin2gray(32'(wbin_next)));
    end

    // Next read pointer: advance only when the reader sees a stored word.
    always_comb begin
        rd_accept  = read_en && !empty;
        rbin_next  = rbin + PTR_W'(rd_accept);
        rgray_next = PTR_W'(bin2gray(32'(rbin_next)));
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wbin[ADDR-1:0]] <= write_data;
        end
    end

    // Write pointer and full flag, judged against the synchronized read pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin  <= '0;
            wgray <= '0;
            full  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            full  <= (wgray_next == (rq2_gray ^ FULL_MASK));
        end
    end

    // Read pointer, registered read word and empty flag against the synchronized write pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rbin      <= '0;
            rgray     <= '0;
            empty     <= 1'b1;
            read_data <= '0;
        end else begin
            rbin  <= rbin_next;
            rgray <= rgray_next;
            empty <= (rgray_next == wq2_gray);
            if (rd_accept) begin
                read_data <= mem[rbin[ADDR-1:0]];
            end
        end
    end

    fifo_ptr_sync #(.PTR_W(PTR_W)) u_sync_w2r (
        .clk       (clk),
        .reset_n   (reset_n),
        .gray_in   (wgray),
        .gray_sync (wq2_gray)
    );

    fifo_ptr_sync #(.PTR_W(PTR_W)) u_sync_r2w (
        .clk       (clk),
        .reset_n   (reset_n),
        .gray_in   (rgray),
        .gray_sync (rq2_gray)
    );

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed self-checking bench for asynchronous_fifo (DEPTH=4, WIDTH=8).
module tb_asynchronous_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             full;
    logic             empty;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] next_wr;
    logic             last_rd_acc;
    int               reads_done;

    typedef struct {
        logic             we;
        logic [WIDTH-1:0] wd;
        logic             re;
        logic             e;
        logic             f;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t tbl [17];

    asynchronous_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of traffic with a scoreboard; acceptance follows the flags the DUT shows.
    task automatic cyc(input logic we, input logic re);
        logic             acc_w;
        logic             acc_r;
        logic [WIDTH-1:0] exp;
        write_en   = we;
        read_en    = re;
        write_data = next_wr;
        acc_w = we && !full;
        acc_r = re && !empty;
        if (acc_r && q.size() == 0) begin
            chk("read_while_model_empty", 32'(acc_r), 32'(0));
            acc_r = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc_w) begin
            q.push_back(next_wr);
            next_wr = next_wr + 8'd1;
        end
        last_rd_acc = acc_r;
        if (acc_r) begin
            exp = q.pop_front();
            chk("stream_read_data", 32'(read_data), 32'(exp));
            reads_done++;
        end
        chk("no_optimistic_full",  32'(!full  && q.size() >= DEPTH), 32'(0));
        chk("no_optimistic_empty", 32'(!empty && q.size() == 0),     32'(0));
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    // Asynchronous reset pulse of 5 ns, landing mid-cycle.
    task automatic async_reset_check(input string tag);
        write_en = 1'b0;
        read_en  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk({tag, "_empty_async"}, 32'(empty), 32'(1));
        chk({tag, "_full_async"},  32'(full),  32'(0));
        chk({tag, "_rdata_async"}, 32'(read_data), 32'(0));
        #4 reset_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk({tag, "_empty_after_release"}, 32'(empty), 32'(1));
    endtask

    initial begin
        int guard;
        reset_n    = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = '0;
        next_wr    = 8'h01;
        reads_done = 0;
        last_rd_acc = 1'b0;

        //            we  wd     re   e  f  rd
        tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[7]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[8]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[9]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[10] = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h13};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h14};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h14};
        tbl[16] = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 8'h14};

        // Power-on reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_empty", 32'(empty), 32'(1));
        chk("reset_full",  32'(full),  32'(0));
        chk("reset_rdata", 32'(read_data), 32'(0));
        reset_n = 1'b1;

        // Single word latency, fill, dropped write, drain, read while empty
        for (int i = 0; i < 17; i++) begin
            write_en   = tbl[i].we;
            write_data = tbl[i].wd;
            read_en    = tbl[i].re;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("vec%0d_full",  i), 32'(full),  32'(tbl[i].f));
            chk($sformatf("vec%0d_rdata", i), 32'(read_data), 32'(tbl[i].rd));
        end

        // Mid-cycle asynchronous reset with non-zero read_data
        async_reset_check("rst5ns");

        // Streaming 0x01..0x0A with both enables high
        next_wr    = 8'h01;
        reads_done = 0;
        guard      = 0;
        while (reads_done < 10 && guard < 200) begin
            cyc(next_wr <= 8'h0A, 1'b1);
            guard++;
        end
        chk("stream_read_count", 32'(reads_done), 32'(10));
        chk("stream_ended_empty", 32'(empty), 32'(1));

        // Repeated fill/drain across the pointer wrap
        for (int round = 0; round < 3; round++) begin
            guard = 0;
            while (!full && guard < 40) begin
                cyc(1'b1, 1'b0);
                guard++;
            end
            chk($sformatf("wrap%0d_full_reached", round), 32'(full), 32'(1));
            chk($sformatf("wrap%0d_count_at_full", round), 32'(q.size()), 32'(DEPTH));
            cyc(1'b1, 1'b0);
            chk($sformatf("wrap%0d_write_dropped", round), 32'(q.size()), 32'(DEPTH));
            guard = 0;
            while (q.size() != 0 && guard < 40) begin
                cyc(1'b0, 1'b1);
                guard++;
            end
            chk($sformatf("wrap%0d_drained", round), 32'(q.size()), 32'(0));
            chk($sformatf("wrap%0d_empty", round), 32'(empty), 32'(1));
        end

        // Reset with three words stored, then 0xAA must be the first word back
        repeat (3) cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        chk("midrst_words_stored", 32'(q.size()), 32'(3));
        chk("midrst_empty_before", 32'(empty), 32'(0));
        async_reset_check("midrst");
        next_wr = 8'hAA;
        cyc(1'b1, 1'b0);
        guard = 0;
        last_rd_acc = 1'b0;
        while (!last_rd_acc && guard < 20) begin
            cyc(1'b0, 1'b1);
            guard++;
        end
        chk("midrst_read_seen", 32'(last_rd_acc), 32'(1));
        chk("midrst_first_word", 32'(read_data), 32'(8'hAA));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
